// File: rtl/rv32i_alu_issue_pkg.sv
// Shared decode constants and types for the RV32I ALU issue controller.
// alu_sel_t is the select encoding understood by the two-cycle execute stage.
package rv32i_alu_issue_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    LUI = 4'd5
  } alu_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } issue_state_t;

  function automatic logic [31:0] sext_imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/rv32i_alu_issue_decoder.sv
// Combinational decode of ALU op, operand sources and destination register.
// Unsupported encodings come out with zero operands and the illegal flag set.
module rv32i_alu_issue_decoder
  import rv32i_alu_issue_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output alu_sel_t    o_alu_sel,
  output logic [31:0] o_operand_one,
  output logic [31:0] o_operand_two,
  output logic [4:0]  o_rd,
  output logic        o_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_op;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign is_op  = (opcode == OPCODE_OP);
  assign o_rd   = i_instr[11:7];

  always_comb begin
    o_alu_sel     = ADD;
    o_operand_one = '0;
    o_operand_two = '0;
    o_illegal     = 1'b1;
    unique case (opcode)
      OPCODE_OP, OPCODE_OP_IMM: begin
        o_operand_one = i_rs1_data;
        o_operand_two = is_op ? i_rs2_data : sext_imm_i(i_instr);
        o_illegal     = 1'b0;
        unique case (funct3)
          // funct7[5] selects SUB only for register-register ops
          FUNCT3_ADD_SUB: o_alu_sel = (is_op && i_instr[30]) ? SUB : ADD;
          FUNCT3_XOR:     o_alu_sel = XOR;
          FUNCT3_OR:      o_alu_sel = OR;
          FUNCT3_AND:     o_alu_sel = AND;
          default:        o_illegal = 1'b1;
        endcase
      end
      OPCODE_LUI: begin
        o_alu_sel     = LUI;
        o_operand_two = {12'b0, i_instr[31:12]};
        o_illegal     = 1'b0;
      end
      default: o_illegal = 1'b1;
    endcase

    if (o_illegal) begin
      o_alu_sel     = ADD;
      o_operand_one = '0;
      o_operand_two = '0;
    end
  end

endmodule

// File: rtl/rv32i_alu_issue.sv
// Issue controller in front of the two-cycle execute stage: accepts one instruction,
// holds the execute request until the result returns, then offers it to writeback.
module rv32i_alu_issue
  import rv32i_alu_issue_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_alu_en,
  output logic [3:0]  o_alu_sel,
  output logic [31:0] o_alu_operand_one,
  output logic [31:0] o_alu_operand_two,
  input  logic        i_alu_data_valid,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_carry_out,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_we,
  output logic [31:0] o_wb_result,
  output logic        o_wb_carry,
  output logic        o_wb_illegal
);

  issue_state_t state_q, state_d;
  alu_sel_t     sel_q, dec_sel;
  logic [31:0]  op_one_q, op_two_q, dec_op_one, dec_op_two;
  logic [31:0]  result_q, result_d;
  logic         carry_q, carry_d;
  logic [4:0]   rd_q, dec_rd;
  logic         illegal_q, dec_illegal;
  logic         accept;

  rv32i_alu_issue_decoder u_decoder (
    .i_instr       (i_instr),
    .i_rs1_data    (i_rs1_data),
    .i_rs2_data    (i_rs2_data),
    .o_alu_sel     (dec_sel),
    .o_operand_one (dec_op_one),
    .o_operand_two (dec_op_two),
    .o_rd          (dec_rd),
    .o_illegal     (dec_illegal)
  );

  assign o_instr_ready = (state_q == IDLE) && !i_rst;
  assign accept        = i_instr_valid && o_instr_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Clearing here leaves the illegal payload with result=0, carry=0
          state_d  = dec_illegal ? DONE : EXEC;
          result_d = '0;
          carry_d  = 1'b0;
        end
      end
      EXEC: begin
        if (i_alu_data_valid) begin
          state_d  = DONE;
          result_d = i_alu_result;
          carry_d  = i_alu_carry_out;
        end
      end
      DONE: begin
        if (i_wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      sel_q     <= ADD;
      op_one_q  <= '0;
      op_two_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      if (accept) begin
        sel_q     <= dec_sel;
        op_one_q  <= dec_op_one;
        op_two_q  <= dec_op_two;
        rd_q      <= dec_rd;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign o_alu_en          = (state_q == EXEC);
  assign o_alu_sel         = sel_q;
  assign o_alu_operand_one = op_one_q;
  assign o_alu_operand_two = op_two_q;

  assign o_wb_valid   = (state_q == DONE);
  assign o_wb_rd      = rd_q;
  assign o_wb_we      = !illegal_q && (rd_q != 5'd0);
  assign o_wb_result  = result_q;
  assign o_wb_carry   = carry_q;
  assign o_wb_illegal = illegal_q;

endmodule
